uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  Framed program loader that sits between the UART receiver and the program RAM.
//  Accepts a byte stream: sync 0xA5, 16-bit word count (LSB first), N words, optional checksum.
//  Assembles each DATA_WIDTH-bit word, writes it to RAM at BASE_ADDR+index, then flags completion.
//  Adds to the fixed 4-byte loader: generic word width, byte order, length header, timeout and error reporting.
// PARAMETERS
//  DATA_WIDTH   32         word width in bits; must be a multiple of 8 (BPW = DATA_WIDTH/8 bytes per word)
//  ADDR_W       10         RAM address width; max word count = 2**ADDR_W
//  BASE_ADDR    0          first RAM address written
//  BIG_ENDIAN   0          0: first byte -> bits [7:0]; 1: first byte -> bits [DATA_WIDTH-1 -: 8]
//  TIMEOUT_CYC  1_000_000  max clk cycles between bytes inside a frame; 0 disables the timeout
// PORTS
//  clk        in   1           system clock
//  rst        in   1           synchronous reset, active-high
//  rx_valid   in   1           one-cycle strobe: rx_byte valid (receiver rx_done)
//  rx_byte    in   8           received byte
//  mem_we     out  1           one-cycle RAM write enable
//  mem_addr   out  ADDR_W      RAM write address
//  mem_wdata  out  DATA_WIDTH  assembled word
//  prog_rdy   out  1           frame loaded successfully (level)
//  err        out  1           frame aborted (level)
//  err_code   out  2           0 none, 1 timeout, 2 length overflow, 3 checksum mismatch
//  state      out  3           current FSM state encoding (debug)
//  word_cnt   out  ADDR_W+1    words written in current frame
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0 (mem_addr=0, mem_wdata=0, word_cnt=0); byte/word counters cleared.
//  - States: IDLE=0, LEN_LO=1, LEN_HI=2, DATA=3, CSUM=4, DONE=5, ERROR=6.
//  - IDLE: rx_byte==0xA5 -> LEN_LO; other bytes ignored.
//  - LEN_LO: latch count[7:0] -> LEN_HI. LEN_HI: latch count[15:8], then:
//    count > 2**ADDR_W -> ERROR code 2; count==0 -> CSUM (macro on) or DONE; else -> DATA.
//  - DATA: bytes shifted into word per BIG_ENDIAN. On word's BPW-th byte, mem_we pulses the NEXT cycle
//    with mem_addr=BASE_ADDR+word_cnt (mod 2**ADDR_W) and the full word; word_cnt increments with the pulse.
//    After the final word -> CSUM (macro on) or DONE.
//  - mem_we is never asserted outside DATA-completion pulses; at most one pulse per BPW accepted bytes.
//  - DONE: prog_rdy=1, registered, asserted the cycle after the last frame byte is accepted
//    (macro off: same cycle as the final mem_we).
//  - ERROR: err=1, err_code held; words already written stay in RAM; prog_rdy=0.
//  - DONE/ERROR exit only on rx_byte==0xA5 -> LEN_LO, clearing prog_rdy, err, err_code, word_cnt same edge.
//  - Timeout: a cycle counter clears on each rx_valid and runs only in LEN_LO..CSUM.
//    Reaching TIMEOUT_CYC -> ERROR code 1. Partial word is discarded.
//  - rx_valid arriving in the same cycle as a mem_we pulse is accepted normally (no stall, no loss).
//  - rst mid-frame: immediate return to IDLE; no further mem_we.
// CONFIGURATION
//  UART_LOADER_CHECKSUM_EN defined:
//    one trailing byte is expected in CSUM. It must equal the XOR of all DATA bytes (0x00 when count==0).
//    Match -> DONE; mismatch -> ERROR code 3.
//  Undefined: no CSUM state is entered; the frame ends after the last data byte; err_code 3 is never produced.
// TESTING
//  1 Reset, then A5 02 00 11 22 33 44 55 66 77 88 (+csum 0x88 if EN), BIG_ENDIAN=0 ->
//    mem_we@0=0x44332211, mem_we@1=0x88776655, prog_rdy=1, word_cnt=2.
//  2 Same stream, BIG_ENDIAN=1 -> words 0x11223344, 0x55667788.
//  3 ADDR_W=2, frame A5 05 00 -> err=1, err_code=2, no mem_we.
//  4 TIMEOUT_CYC=100, A5 01 00 11 22 then idle 100 cycles -> err_code=1, no mem_we.
//    Then A5 00 00 (+00) -> err=0, prog_rdy=1.
//  5 EN: A5 01 00 01 02 03 04 FF -> one mem_we, then err_code=3, prog_rdy=0.
//  6 rst pulse after 3rd data byte, then 40 random non-A5 bytes -> state=IDLE, no mem_we, outputs 0.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: framed byte-stream loader that assembles words into program RAM.
// Optional trailing XOR checksum byte is enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_prog_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_W      = 10,
    parameter int BASE_ADDR   = 0,
    parameter bit BIG_ENDIAN  = 1'b0,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  prog_rdy,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [2:0]            state,
    output logic [ADDR_W:0]       word_cnt
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BW  = $clog2(BPW + 1);
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [ADDR_W:0] WC_ONE = 1;
    localparam logic [BW-1:0] BI_ONE = 1;
    localparam logic [BW-1:0] BI_LAST = BW'(BPW - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

`ifdef UART_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam state_t S_END = CSUM_EN ? S_CSUM : S_DONE;

    state_t                st;
    logic [15:0]           len;
    logic [BW-1:0]         byte_idx;
    logic [DATA_WIDTH-1:0] word_buf;
    logic [DATA_WIDTH-1:0] word_nxt;
    logic [31:0]           tmr;
    logic                  last_byte;
    logic                  last_word;
    logic                  active;
    logic                  timed_out;
    logic [15:0]           len_full;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    assign state     = st;
    assign last_byte = (byte_idx == BI_LAST);
    assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);
    assign active    = (st == S_LEN_LO) || (st == S_LEN_HI) ||
                       (st == S_DATA) || (st == S_CSUM);
    assign timed_out = (TIMEOUT_CYC != 0) &&
                       (tmr == 32'(TIMEOUT_CYC - 1));
    assign len_full  = {rx_byte, len[7:0]};

    // Merge the incoming byte into the partially assembled word
    always_comb begin
        if (BIG_ENDIAN)
            word_nxt = (word_buf << 8) | DATA_WIDTH'(rx_byte);
        else
            word_nxt = (word_buf >> 8) |
                       (DATA_WIDTH'(rx_byte) << (DATA_WIDTH - 8));
    end

    // Frame parser FSM with registered RAM write and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= S_IDLE;
            len       <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            tmr       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            prog_rdy  <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            word_cnt  <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (active && !rx_valid)
                tmr <= tmr + 32'd1;
            else
                tmr <= '0;

            if (rx_valid) begin
                case (st)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (rx_byte == SYNC) begin
                            st       <= S_LEN_LO;
                            len      <= '0;
                            byte_idx <= '0;
                            word_buf <= '0;
                            prog_rdy <= 1'b0;
                            err      <= 1'b0;
                            err_code <= 2'd0;
                            word_cnt <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                            csum     <= 8'd0;
`endif
                        end
                    end
                    S_LEN_LO: begin
                        len[7:0] <= rx_byte;
                        st       <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        len[15:8] <= rx_byte;
                        if (32'(len_full) > (32'd1 << ADDR_W)) begin
                            st       <= S_ERROR;
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end else if (len_full == 16'd0) begin
                            st       <= S_END;
                            prog_rdy <= !CSUM_EN;
                        end else begin
                            st <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        word_buf <= word_nxt;
`ifdef UART_LOADER_CHECKSUM_EN
                        csum     <= csum ^ rx_byte;
`endif
                        if (last_byte) begin
                            byte_idx  <= '0;
                            mem_we    <= 1'b1;
                            mem_addr  <= ADDR_W'(BASE_ADDR) +
                                         word_cnt[ADDR_W-1:0];
                            mem_wdata <= word_nxt;
                            word_cnt  <= word_cnt + WC_ONE;
                            if (last_word) begin
                                st       <= S_END;
                                prog_rdy <= !CSUM_EN;
                            end
                        end else begin
                            byte_idx <= byte_idx + BI_ONE;
                        end
                    end
`ifdef UART_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (rx_byte == csum) begin
                            st       <= S_DONE;
                            prog_rdy <= 1'b1;
                        end else begin
                            st       <= S_ERROR;
                            err      <= 1'b1;
                            err_code <= 2'd3;
                        end
                    end
`endif
                    default: ;
                endcase
            end else if (active && timed_out) begin
                st       <= S_ERROR;
                err      <= 1'b1;
                err_code <= 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed frames into two loader instances,
// RAM writes checked by per-instance scoreboard queues.
module tb_uart_prog_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rxv_a, rxv_b;
    logic [7:0]  rxb_a, rxb_b;

    logic        we_a, rdy_a, err_a;
    logic [9:0]  addr_a;
    logic [31:0] wd_a;
    logic [1:0]  ec_a;
    logic [2:0]  st_a;
    logic [10:0] wc_a;

    logic        we_b, rdy_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wd_b;
    logic [1:0]  ec_b;
    logic [2:0]  st_b;
    logic [2:0]  wc_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [41:0] q_a[$];
    logic [41:0] q_b[$];
    logic [7:0]  stim[$];

    uart_prog_loader #(
        .DATA_WIDTH(32), .ADDR_W(10), .BASE_ADDR(0),
        .BIG_ENDIAN(1'b0), .TIMEOUT_CYC(100)
    ) dut_a (
        .clk(clk), .rst(rst), .rx_valid(rxv_a), .rx_byte(rxb_a),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
        .prog_rdy(rdy_a), .err(err_a), .err_code(ec_a),
        .state(st_a), .word_cnt(wc_a)
    );

    uart_prog_loader #(
        .DATA_WIDTH(32), .ADDR_W(2), .BASE_ADDR(0),
        .BIG_ENDIAN(1'b1), .TIMEOUT_CYC(100)
    ) dut_b (
        .clk(clk), .rst(rst), .rx_valid(rxv_b), .rx_byte(rxb_b),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
        .prog_rdy(rdy_b), .err(err_b), .err_code(ec_b),
        .state(st_b), .word_cnt(wc_b)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic play_a();
        foreach (stim[i]) begin
            rxv_a = 1'b1;
            rxb_a = stim[i];
            @(negedge clk);
            rxv_a = 1'b0;
        end
    endtask

    task automatic play_b();
        foreach (stim[i]) begin
            rxv_b = 1'b1;
            rxb_b = stim[i];
            @(negedge clk);
            rxv_b = 1'b0;
        end
    endtask

    // Monitor for instance A writes
    always @(negedge clk) begin
        if (we_a) begin
            if (q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_we: got addr %0h data %0h expected no write",
                         addr_a, wd_a);
            end else begin
                chk("a_we", 64'({addr_a, wd_a}), 64'(q_a.pop_front()));
            end
        end
    end

    // Monitor for instance B writes
    always @(negedge clk) begin
        if (we_b) begin
            if (q_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_we: got addr %0h data %0h expected no write",
                         addr_b, wd_b);
            end else begin
                chk("b_we", 64'({8'd0, addr_b, wd_b}), 64'(q_b.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        rxv_a = 1'b0;
        rxv_b = 1'b0;
        rxb_a = 8'd0;
        rxb_b = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_a", 64'({we_a, addr_a, wd_a, rdy_a, err_a, ec_a, st_a, wc_a}), 64'd0);
        chk("reset_b", 64'({we_b, addr_b, wd_b, rdy_b, err_b, ec_b, st_b, wc_b}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Little-endian two-word frame, back-to-back bytes
        q_a.push_back({10'd0, 32'h44332211});
        q_a.push_back({10'd1, 32'h88776655});
        stim = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88};
`ifdef UART_LOADER_CHECKSUM_EN
        stim.push_back(8'h88);
`endif
        play_a();
        chk("t1_rdy", 64'(rdy_a), 64'd1);
        chk("t1_err", 64'(err_a), 64'd0);
        chk("t1_wc", 64'(wc_a), 64'd2);
        chk("t1_state", 64'(st_a), 64'd5);

        // Same stream into big-endian instance
        q_b.push_back({10'd0, 32'h11223344});
        q_b.push_back({10'd1, 32'h55667788});
        play_b();
        chk("t2_rdy", 64'(rdy_b), 64'd1);
        chk("t2_wc", 64'(wc_b), 64'd2);
        chk("t2_state", 64'(st_b), 64'd5);

        // Length overflow on ADDR_W=2 instance
        stim = {8'hA5, 8'h05, 8'h00};
        play_b();
        chk("t3_err", 64'(err_b), 64'd1);
        chk("t3_code", 64'(ec_b), 64'd2);
        chk("t3_state", 64'(st_b), 64'd6);
        chk("t3_rdy", 64'(rdy_b), 64'd0);
        chk("t3_wc", 64'(wc_b), 64'd0);

        // Timeout mid-word, then empty frame recovers
        stim = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        play_a();
        chk("t4_pre_rdy", 64'(rdy_a), 64'd0);
        repeat (100) @(negedge clk);
        chk("t4_err", 64'(err_a), 64'd1);
        chk("t4_code", 64'(ec_a), 64'd1);
        chk("t4_state", 64'(st_a), 64'd6);
        chk("t4_wc", 64'(wc_a), 64'd0);
        stim = {8'hA5, 8'h00, 8'h00};
`ifdef UART_LOADER_CHECKSUM_EN
        stim.push_back(8'h00);
`endif
        play_a();
        chk("t4r_err", 64'(err_a), 64'd0);
        chk("t4r_code", 64'(ec_a), 64'd0);
        chk("t4r_rdy", 64'(rdy_a), 64'd1);
        chk("t4r_wc", 64'(wc_a), 64'd0);

`ifdef UART_LOADER_CHECKSUM_EN
        // Checksum mismatch after one written word
        q_a.push_back({10'd0, 32'h04030201});
        stim = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
        play_a();
        chk("t5_err", 64'(err_a), 64'd1);
        chk("t5_code", 64'(ec_a), 64'd3);
        chk("t5_rdy", 64'(rdy_a), 64'd0);
        chk("t5_wc", 64'(wc_a), 64'd1);
`endif

        // Reset mid-frame, then random non-sync noise
        stim = {8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
        play_a();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stim = {};
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            stim.push_back(b);
        end
        play_a();
        repeat (2) @(negedge clk);
        chk("t6_outputs", 64'({we_a, addr_a, wd_a, rdy_a, err_a, ec_a, st_a, wc_a}), 64'd0);
        chk("t6_state", 64'(st_a), 64'd0);

        chk("sb_a_empty", 64'(q_a.size()), 64'd0);
        chk("sb_b_empty", 64'(q_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
